alu_stream: RTL and testbench

//   Streaming, parametrised successor to the combinational producer/consumer ALU.
//   - Accepts operand/opcode transactions on a valid/ready input port.
//   - Computes one of eight operations and buffers results in a DEPTH-entry FIFO.
//   - Returns results in order on a valid/ready output port.
//   - Sits between an operand producer and a result consumer that can stall independently.
//

---
 rtl/alu_stream_if.sv | 36 +++
 rtl/alu_stream.sv | 70 +++++++
 tb/tb_alu_stream.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_stream_if.sv
// alu_stream_if: operand/result stream bundle for alu_stream; ALU_STREAM_FLAGS_EN adds out_ovf/out_zero
interface alu_stream_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_op1;
  logic [WIDTH-1:0]         in_op2;
  logic [2:0]               in_opcode;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_res;
  logic [$clog2(DEPTH):0]   count;
`ifdef ALU_STREAM_FLAGS_EN
  logic                     out_ovf;
  logic                     out_zero;
  modport master (
    output in_valid, in_op1, in_op2, in_opcode, out_ready,
    input  in_ready, out_valid, out_res, count, out_ovf, out_zero
  );
  modport slave (
    input  in_valid, in_op1, in_op2, in_opcode, out_ready,
    output in_ready, out_valid, out_res, count, out_ovf, out_zero
  );
`else
  modport master (
    output in_valid, in_op1, in_op2, in_opcode, out_ready,
    input  in_ready, out_valid, out_res, count
  );
  modport slave (
    input  in_valid, in_op1, in_op2, in_opcode, out_ready,
    output in_ready, out_valid, out_res, count
  );
`endif
endinterface

// File: rtl/alu_stream.sv
// alu_stream: 8-op streaming ALU feeding a DEPTH-entry in-order result FIFO; ALU_STREAM_FLAGS_EN adds per-entry ovf/zero flags
module alu_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  alu_stream_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] res, sum, dif, last;
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             acc, con;
  assign sum = s.in_op1 + s.in_op2;
  assign dif = s.in_op1 - s.in_op2;
  always_comb begin
    res = '0;
    case (s.in_opcode)
      3'd0: res = sum;
      3'd1: res = dif;
      3'd2: res = s.in_op1 & s.in_op2;
      3'd3: res = s.in_op1 | s.in_op2;
      3'd4: res = s.in_op1 ^ s.in_op2;
      3'd5: res = {{(WIDTH-1){1'b0}}, $signed(s.in_op1) < $signed(s.in_op2)};
      3'd6: res = s.in_op1 << s.in_op2[SW-1:0];
      3'd7: res = s.in_op1 >> s.in_op2[SW-1:0];
    endcase
  end
  assign acc         = s.in_valid & s.in_ready;
  assign con         = s.out_valid & s.out_ready;
  assign s.in_ready  = !rst && cnt != FULL;
  assign s.out_valid = cnt != '0;
  assign s.count     = cnt;
  // when empty, keep presenting the last consumed result rather than a stale slot
  assign s.out_res   = s.out_valid ? mem[rptr] : last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      if (acc) wptr <= wptr + 1'b1;
      if (con) rptr <= rptr + 1'b1;
      if (con) last <= mem[rptr];
      cnt <= cnt + (AW+1)'(acc) - (AW+1)'(con);
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wptr] <= res;
  end
`ifdef ALU_STREAM_FLAGS_EN
  logic [1:0] fmem [DEPTH];
  logic       ovf;
  logic       msb1, msb2;
  assign msb1 = s.in_op1[WIDTH-1];
  assign msb2 = s.in_op2[WIDTH-1];
  assign ovf = s.in_opcode == 3'd0 ? (msb1 == msb2) && (sum[WIDTH-1] != msb1) :
               s.in_opcode == 3'd1 ? (msb1 != msb2) && (dif[WIDTH-1] != msb1) : 1'b0;
  assign s.out_ovf  = s.out_valid & fmem[rptr][1];
  assign s.out_zero = s.out_valid & fmem[rptr][0];
  always_ff @(posedge clk) begin
    if (acc) fmem[wptr] <= {ovf, res == '0};
  end
`endif
endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: scoreboard bench for alu_stream (WIDTH=32, DEPTH=4)
module tb_alu_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [33:0] q [$];
  int   push_cyc [$];
  int   pop_cyc [$];

  alu_stream_if #(.WIDTH(32), .DEPTH(4)) bus ();
  alu_stream #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      3'd7: r = a >> b[4:0];
    endcase
    return {v, r == 32'd0, r};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("sb_unexpected_output", 64'(bus.out_res), 64'hdead);
        else begin
          logic [33:0] e;
          e = q.pop_front();
          check("res", 64'(bus.out_res), 64'(e[31:0]));
`ifdef ALU_STREAM_FLAGS_EN
          check("ovf", 64'(bus.out_ovf), 64'(e[33]));
          check("zero", 64'(bus.out_zero), 64'(e[32]));
`endif
          pop_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_op1, bus.in_op2, bus.in_opcode));
        push_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_opcode = op;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (bus.count != 0 || q.size() != 0); i++) @(negedge clk);
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_sb", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0;
    bus.in_valid  = 1'b0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_out_res", 64'(bus.out_res), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    // single ADD with one-cycle latency, then hold after empty
    send(32'h1234, 32'h4321, 3'd0);
    @(negedge clk);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_res", 64'(bus.out_res), 64'h5555);
    check("t1_count", 64'(bus.count), 64'd1);
    @(negedge clk);
    check("t1_count_after", 64'(bus.count), 64'd0);
    check("t1_valid_after", 64'(bus.out_valid), 64'd0);
    check("t1_hold", 64'(bus.out_res), 64'h5555);
    @(posedge clk);
    #1;
    send(32'h0, 32'h1, 3'd1);
    send(32'hFFFF_FFFF, 32'h1, 3'd5);
    send(32'h7FFF_FFFF, 32'h1, 3'd0);
    send(32'h8000_0000, 32'h1, 3'd1);
    send(32'h5, 32'h5, 3'd1);
    send(32'h8000_0001, 32'hFFFF_FFE4, 3'd6);
    send(32'h8000_0001, 32'h0000_0101, 3'd7);
    drain();
    // fill with consumer stalled, then overlap full consume with a pending input
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), 32'd0, 3'd0);
    @(negedge clk);
    check("full_count", 64'(bus.count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_op1    = 32'd5;
    bus.in_op2    = 32'd0;
    bus.in_opcode = 3'd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_ignore_count", 64'(bus.count), 64'd4);
    check("full_ignore_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("after_full_count", 64'(bus.count), 64'd3);
    check("after_full_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_op1 = 32'd6;
    @(negedge clk);
    check("acc_con_count", 64'(bus.count), 64'd3);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();
    // back-to-back stream across pointer wraps
    s0 = pop_cyc.size();
    p0 = push_cyc.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send($urandom, 32'($urandom_range(0, 63)), 3'(i));
    drain();
    check("stream_pops", 64'(pop_cyc.size() - s0), 64'd16);
    if (pop_cyc.size() >= s0 + 16 && push_cyc.size() > p0) begin
      check("stream_latency", 64'(pop_cyc[s0] - push_cyc[p0]), 64'd1);
      check("stream_no_bubble", 64'(pop_cyc[s0+15] - pop_cyc[s0]), 64'd15);
    end
    // asynchronous reset mid-stream flushes everything
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 32'h1, 3'd0);
    @(negedge clk);
    check("pre_rst_count", 64'(bus.count), 64'd3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_count", 64'(bus.count), 64'd0);
    check("async_rst_ready", 64'(bus.in_ready), 64'd0);
    check("async_rst_res", 64'(bus.out_res), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32'd100, 32'd23, 3'd0);
    @(negedge clk);
    check("post_rst_res", 64'(bus.out_res), 64'd123);
    drain();
    repeat (3) @(negedge clk);
    check("no_stale_valid", 64'(bus.out_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
